// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Step counter must reach WIDTH-1 and is sized to also hold WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_twos_abs.sv
// Splits an operand into an unsigned magnitude and a sign bit.
module twos_abs #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] magnitude,
  output logic             sign
);

  // -2^(WIDTH-1) negates to itself, which is exactly its unsigned magnitude.
  assign sign      = signed_mode & value[WIDTH-1];
  assign magnitude = sign ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 LSB-first shift-add multiplier, unsigned or two's-complement, WIDTH cycles per product.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic [1:0]         state_dbg
);

  localparam int CW = cnt_width(WIDTH);
  localparam int AW = 2 * WIDTH + 1;

  // Handshake: start is honoured only in IDLE or DONE and latches a, b and
  // signed_mode on that edge; busy covers the WIDTH step cycles, done is a
  // single-cycle pulse on the edge p is loaded, and busy/done never overlap.

  mul_state_e       state;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             neg;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sign_a, sign_b;
  logic               accept;
  logic               last_step;
  logic [WIDTH:0]     sum;
  logic [AW-1:0]      acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] p_next;

  twos_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value       (a),
    .signed_mode (signed_mode),
    .magnitude   (mag_a),
    .sign        (sign_a)
  );

  twos_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value       (b),
    .signed_mode (signed_mode),
    .magnitude   (mag_b),
    .sign        (sign_b)
  );

  assign accept    = start && (state == IDLE || state == DONE);
  assign last_step = (state == RUN) && (cnt == CW'(WIDTH - 1));

  // Upper half keeps its carry bit, so the add can never overflow.
  assign sum      = acc[AW-1:WIDTH] + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
  assign acc_next = {1'b0, sum, acc[WIDTH-1:1]};
  assign prod     = acc_next[2*WIDTH-1:0];
  assign p_next   = neg ? (~prod + (2*WIDTH)'(1)) : prod;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      p      <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mcand  <= mag_a;
        mplier <= mag_b;
        neg    <= sign_a ^ sign_b;
        acc    <= '0;
        cnt    <= '0;
        busy   <= 1'b1;
        state  <= RUN;
      end else begin
        case (state)
          RUN: begin
            acc    <= acc_next;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last_step) begin
              p     <= p_next;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier, the next generation of the team's fixed 3-bit combinational multiplier. It computes a full-width product of two WIDTH-bit operands in WIDTH clock cycles, in unsigned or two's-complement signed mode. A start/busy/done handshake lets it sit behind a controller or bus slave, with area proportional to WIDTH rather than WIDTH².

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when the block is idle or done.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while a multiplication is in progress.
- done  output  1  one-cycle pulse marking p valid.
- p  output  2*WIDTH  product; holds until the next accepted start.

## Operation
- States:
  - IDLE (reset state).
  - RUN: iterates WIDTH steps.
  - DONE: one cycle, done=1.
- Transitions:
  - IDLE→RUN on start.
  - RUN→DONE after step WIDTH.
  - DONE→RUN on start, otherwise DONE→IDLE.
- Accept: start=1 in IDLE or DONE latches a, b and signed_mode.
  - start in RUN is ignored. No queueing and no error flag.
- Signed mode: latch |a| and |b| as WIDTH-bit unsigned magnitudes, plus neg = sign(a) XOR sign(b).
  - The most negative value -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits in WIDTH bits unsigned and needs no special case.
  - On the final step p = neg ? -acc : acc, taken mod 2^(2*WIDTH).
  - A zero result is never negated into a nonzero value.
- Unsigned mode: neg = 0 and magnitudes equal the operands.
- Step (radix-2, LSB first): if the multiplier LSB is 1, add the multiplicand to the upper half of the 2*WIDTH+1-bit accumulator, then shift the accumulator right by 1.
  - The carry bit is kept, so no overflow is possible.
- Step counter: $clog2(WIDTH+1) bits, cleared on accept.
- p is written only on the final step and is not updated during RUN.
- Reset (asynchronous, any state including mid-RUN): state=IDLE, busy=0, done=0, p=0, accumulator and counter=0.
  - The in-flight operation is discarded.

## Timing
- Edge E0 (start accepted): state→RUN and busy=1 from E0.
- Edges E1..E(WIDTH): one step each.
  - At E(WIDTH): p is loaded, state→DONE, busy=0, done=1.
- Latency: WIDTH cycles from the accepting edge to done high.
- Back-to-back throughput: one result every WIDTH+1 cycles, with start asserted during DONE.
- done is high for exactly one cycle. busy and done are never high together.
- All outputs are registered; there is no combinational path from the inputs to the outputs.

## Structure
- Shared package mul_pkg:
  - state enum mul_state_e {IDLE, RUN, DONE}.
  - localparam helper for the counter width.
- One sub-module: twos_abs (parametrised WIDTH).
  - Inputs: value and signed_mode.
  - Outputs: magnitude and sign.
  - Instantiated once for a and once for b.
- Final conditional negation is done in-line.

## Test plan
- WIDTH=3, unsigned, pairs (2,6),(4,7),(3,3),(5,5) → p = 12, 28, 9, 25. done pulses 3 cycles after each start.
- WIDTH=8, signed:
  - a=-128, b=-128 → p=16384 (0x4000).
  - a=-128, b=127 → p=-16256 (0xC080).
  - a=-1, b=0 → p=0.
- WIDTH=8, unsigned: a=255, b=255 → p=65025 (0xFE01). busy high for exactly 8 cycles.
- Back-to-back: start held across DONE with (7,9) then (10,10) → p=63 then p=100. done pulses 9 cycles apart.
- start re-asserted with a=1, b=1 during RUN of (200,3) → ignored; p=600 (0x0258).
- Assert rst_n=0 for one cycle during step 4 of a WIDTH=8 run:
  - Outputs go to zero immediately.
  - No done pulse.
  - A new start after reset completes correctly.
